pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator. Feeds the fetch stage with a valid/ready PC stream.
//  Handles sequential advance, backpressure, prioritised redirects (exception > branch) and halt/resume.
//  Tags every PC with an epoch so downstream stages can drop stale fetches after a redirect.
// PARAMETERS
//  XLEN         32            PC width in bits
//  RESET_VEC    32'h0000_0000 first PC after reset
//  FETCH_BYTES  4             sequential increment; power of 2, >=1
//  EPOCH_W      2             epoch counter width
//  TRAP_VEC     32'h0000_0100 target on misaligned redirect (only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset, asynchronous, active-high
//  exc_valid      in   1        exception redirect request
//  exc_pc         in   XLEN     exception target
//  redirect_valid in   1        branch/jump redirect request
//  redirect_pc    in   XLEN     branch/jump target
//  halt_req       in   1        stop issuing PCs
//  resume_req     in   1        restart issuing PCs
//  fetch_ready    in   1        fetch accepts current PC
//  fetch_valid    out  1        fetch_pc is valid
//  fetch_pc       out  XLEN     PC offered to fetch
//  fetch_epoch    out  EPOCH_W  epoch tag of fetch_pc
//  misalign_flag  out  1        1-cycle pulse: misaligned redirect trapped
// BEHAVIOUR
//  Reset (async): state=BOOT; fetch_pc=RESET_VEC; fetch_valid=0; fetch_epoch=0; misalign_flag=0.
//  FSM states:
//   - BOOT: lasts exactly one cycle, then RUN.
//   - RUN: fetch_valid=1.
//   - HALT: fetch_valid=0.
//  Handshake:
//   - Transfer = fetch_valid & fetch_ready.
//   - On transfer: fetch_pc <= fetch_pc + FETCH_BYTES, modulo 2^XLEN (0xFFFF_FFFC+4 -> 0x0).
//   - With no transfer and no redirect: fetch_pc and fetch_epoch are held stable.
//  Per-cycle priority: exc_valid > redirect_valid > halt_req/resume_req > sequential advance.
//  Redirects:
//   - Next cycle: fetch_pc=target; fetch_epoch+=1 (wraps at 2^EPOCH_W).
//   - Applied regardless of fetch_ready. Any same-cycle transfer advance is discarded.
//   - Latency: 1 cycle. Accepted in all states except BOOT, where they are ignored.
//   - In HALT a redirect updates fetch_pc/epoch; state stays HALT.
//  Halt/resume:
//   - halt_req in RUN (no redirect): next state HALT. A same-cycle transfer still advances fetch_pc.
//   - resume_req in HALT: next state RUN; fetch_valid=1 next cycle.
//   - halt_req is ignored in HALT. resume_req is ignored in RUN/BOOT.
//   - halt_req and redirect in the same cycle: redirect applied, halt taken too (state HALT).
//  Misalignment: target[log2(FETCH_BYTES)-1:0] != 0; see CONFIGURATION.
//  rst mid-operation: immediate return to reset values; in-flight redirect/halt lost.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//   - Misaligned redirect target replaced by TRAP_VEC.
//   - misalign_flag=1 for exactly the cycle fetch_pc first shows TRAP_VEC.
//   - fetch_epoch still increments by 1.
//  PC_MISALIGN_TRAP_EN undefined:
//   - Target low log2(FETCH_BYTES) bits forced to 0.
//   - misalign_flag tied to 0; TRAP_VEC unused.
// TESTING (defaults)
//  1. Release rst, fetch_ready=1 -> cycle1 valid=0 pc=0x0; cycle2 valid=1 pc=0x0; then 0x4, 0x8, 0xC.
//  2. At pc=0x8, fetch_ready=0 for 3 cycles -> pc=0x8, valid=1 throughout; ready=1 -> 0xC.
//  3. Same cycle exc_valid(0x100) + redirect_valid(0x200), ready=0 -> next pc=0x100, epoch 0->1.
//  4. redirect_pc=0xFFFF_FFFC, then ready=1 -> pc=0xFFFF_FFFC then 0x0; epoch +1 only once.
//  5. redirect_pc=0x202 -> macro off: pc=0x200, flag=0.
//     Macro on: pc=0x100, flag=1 one cycle, epoch+1.
//  6. halt_req -> valid=0 next cycle, pc held; redirect 0x40 in HALT -> pc=0x40, valid=0;
//     resume_req -> valid=1, pc=0x40.
//     Assert rst in RUN -> valid=0, pc=0x0, epoch=0 immediately.

Source files
------------

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_if
// Description : Redirect, halt/resume and fetch-handshake bundle between the
//               program-counter generator (master) and the fetch stage plus
//               redirect sources (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 2
);

  // Redirect sources
  logic               exc_valid;
  logic [XLEN-1:0]    exc_pc;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  // Flow control
  logic               halt_req;
  logic               resume_req;

  // Fetch handshake
  logic               fetch_ready;
  logic               fetch_valid;
  logic [XLEN-1:0]    fetch_pc;
  logic [EPOCH_W-1:0] fetch_epoch;
  logic               misalign_flag;

  // PC generator side
  modport master (
    input  exc_valid, exc_pc, redirect_valid, redirect_pc,
    input  halt_req, resume_req, fetch_ready,
    output fetch_valid, fetch_pc, fetch_epoch, misalign_flag
  );

  // Fetch stage / redirect source side
  modport slave (
    output exc_valid, exc_pc, redirect_valid, redirect_pc,
    output halt_req, resume_req, fetch_ready,
    input  fetch_valid, fetch_pc, fetch_epoch, misalign_flag
  );

endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator feeding the fetch stage through a
//               valid/ready stream. Sequential advance, backpressure,
//               prioritised redirects (exception > branch), halt/resume and
//               an epoch tag that bumps on every accepted redirect.
//               Optional feature macro: PC_MISALIGN_TRAP_EN
//                 defined   -> misaligned redirect targets go to TRAP_VEC and
//                              misalign_flag pulses for one cycle
//                 undefined -> misaligned targets are rounded down to the
//                              fetch alignment, misalign_flag tied low
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter int              FETCH_BYTES = 4,
  parameter int              EPOCH_W     = 2,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100
) (
  input  wire logic clk,
  input  wire logic rst,
  pc_gen_if.master  bus
);

  // Low address bits that must be zero for an aligned fetch address.
  // FETCH_BYTES is a power of two, so FETCH_BYTES-1 is exactly that mask
  // (zero when FETCH_BYTES == 1, i.e. nothing can be misaligned).
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(FETCH_BYTES - 1);
  localparam logic [XLEN-1:0] FETCH_INC  = XLEN'(FETCH_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               flag_q, flag_d;

  logic               valid_w;
  logic               transfer_w;
  logic               redir_take_w;
  logic [XLEN-1:0]    raw_target_w;
  logic               misaligned_w;
  logic [XLEN-1:0]    target_w;
  logic               trap_w;

  // Stream is only offered while running; BOOT and HALT present nothing.
  assign valid_w    = (state_q == ST_RUN);
  assign transfer_w = valid_w & bus.fetch_ready;

  // Redirects are ignored during the single BOOT cycle; exception wins.
  assign redir_take_w = (state_q != ST_BOOT) & (bus.exc_valid | bus.redirect_valid);
  assign raw_target_w = bus.exc_valid ? bus.exc_pc : bus.redirect_pc;
  assign misaligned_w = |(raw_target_w & ALIGN_MASK);

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned targets are diverted to the trap vector and flagged.
  assign target_w = misaligned_w ? TRAP_VEC : raw_target_w;
  assign trap_w   = misaligned_w;
`else
  // Misaligned targets are silently rounded down; the trap vector is unused.
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign target_w        = raw_target_w & ~ALIGN_MASK;
  assign trap_w          = 1'b0;
`endif

  // State, PC, epoch and trap-flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      epoch_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state logic: halt/resume steer the FSM independently of redirects;
  // a redirect overrides any sequential advance in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    flag_d  = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (bus.halt_req)   state_d = ST_HALT;
      ST_HALT: if (bus.resume_req) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (redir_take_w) begin
      pc_d    = target_w;
      epoch_d = epoch_q + EPOCH_W'(1);
      flag_d  = trap_w;
    end else if (transfer_w) begin
      pc_d    = pc_q + FETCH_INC;
    end
  end

  assign bus.fetch_valid   = valid_w;
  assign bus.fetch_pc      = pc_q;
  assign bus.fetch_epoch   = epoch_q;
  assign bus.misalign_flag = flag_q;

endmodule : pc_gen
`default_nettype wire
